bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// The result and overflow flag are held stable between done pulses.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_reg, state_next;
   logic [BIN_W-1:0]    bin_reg, bin_next, bin_shift;
   logic [4*DIGITS-1:0] work_reg, work_next, work_adj, work_shift;
   logic [4*DIGITS-1:0] bcd_reg, bcd_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                ovf_work_reg, ovf_work_next;
   logic                ovf_reg, ovf_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                carry;

   // Add-3 correction on every digit in parallel; 4-bit wrap is safe since digits stay <= 9.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5) ?
                                      work_reg[4*gi +: 4] + 4'd3 : work_reg[4*gi +: 4];
      end
   endgenerate

   assign carry      = work_adj[4*DIGITS-1];
   assign work_shift = {work_adj[4*DIGITS-2:0], bin_reg[BIN_W-1]};
   assign bin_shift  = bin_reg << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bin_reg      <= '0;
         work_reg     <= '0;
         cnt_reg      <= '0;
         ovf_work_reg <= 1'b0;
         bcd_reg      <= '0;
         ovf_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bin_reg      <= bin_next;
         work_reg     <= work_next;
         cnt_reg      <= cnt_next;
         ovf_work_reg <= ovf_work_next;
         bcd_reg      <= bcd_next;
         ovf_reg      <= ovf_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bin_next      = bin_reg;
      work_next     = work_reg;
      cnt_next      = cnt_reg;
      ovf_work_next = ovf_work_reg;
      bcd_next      = bcd_reg;
      ovf_next      = ovf_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               bin_next      = bin_in;
               work_next     = '0;
               cnt_next      = CNT_W'(BIN_W);
               ovf_work_next = 1'b0;
               busy_next     = 1'b1;
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            bin_next      = bin_shift;
            work_next     = work_shift;
            ovf_work_next = ovf_work_reg | carry;
            cnt_next      = cnt_reg - 1'b1;
            // Last iteration publishes the post-shift value directly.
            if (cnt_reg == CNT_W'(1)) begin
               state_next = DONE;
               bcd_next   = work_shift;
               ovf_next   = ovf_work_reg | carry;
               done_next  = 1'b1;
               busy_next  = 1'b0;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign bcd_out  = bcd_reg;
   assign overflow = ovf_reg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share stimulus;
// results are checked by a queue-based scoreboard fed by the stimulus process.
module tb_bin_to_bcd_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bin_in = 8'd0;
   logic        busy3, done3, ovf3;
   logic [11:0] bcd3;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;

   typedef struct packed {logic [11:0] bcd; logic ovf;} exp_t;
   exp_t q3[$];
   exp_t q2[$];

   int checks = 0;
   int fails  = 0;
   logic [11:0] last3 = 12'h000;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3));

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per done pulse on each instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done3) begin
         if (q3.size() == 0) begin
            checks++; fails++;
            $display("FAIL d3_unexpected_done: got done with bcd %0h, expected no done", bcd3);
         end else begin
            e = q3.pop_front();
            chk("d3_bcd", 32'(bcd3), 32'(e.bcd));
            chk("d3_ovf", 32'(ovf3), 32'(e.ovf));
            for (int d = 0; d < 3; d++)
               chk("d3_digit_range", 32'(bcd3[4*d +: 4] <= 4'd9), 32'd1);
            $display("d3 done: bcd=%03h ovf=%0d", bcd3, ovf3);
         end
      end
      if (rst_n && done2) begin
         if (q2.size() == 0) begin
            checks++; fails++;
            $display("FAIL d2_unexpected_done: got done with bcd %0h, expected no done", bcd2);
         end else begin
            e = q2.pop_front();
            chk("d2_bcd", 32'(bcd2), 32'(e.bcd));
            chk("d2_ovf", 32'(ovf2), 32'(e.ovf));
            for (int d = 0; d < 2; d++)
               chk("d2_digit_range", 32'(bcd2[4*d +: 4] <= 4'd9), 32'd1);
            $display("d2 done: bcd=%02h ovf=%0d", bcd2, ovf2);
         end
      end
   end

   // One conversion; glitch_k > 0 pulses start (value 200) while busy.
   task automatic convert(input logic [7:0] v, input logic [11:0] e3, input logic o3,
                          input logic [7:0] e2, input logic o2, input int glitch_k);
      int k;
      int busy_cnt;
      logic got;
      @(negedge clk);
      start  = 1'b1;
      bin_in = v;
      q3.push_back('{bcd: e3, ovf: o3});
      q2.push_back('{bcd: {4'h0, e2}, ovf: o2});
      k = 0; busy_cnt = 0; got = 1'b0;
      while (!got && k < 30) begin
         @(negedge clk);
         k++;
         start  = 1'b0;
         bin_in = 8'($urandom_range(0, 255));
         if (busy3) busy_cnt++;
         if (k == 4) chk("hold_during_shift", 32'(bcd3), 32'(last3));
         if (k == glitch_k) begin
            start  = 1'b1;
            bin_in = 8'd200;
         end
         if (done3) got = 1'b1;
      end
      chk("latency_edges", 32'(k), 32'd9);
      chk("busy_cycles", 32'(busy_cnt), 32'd8);
      chk("done_sync", 32'(done2), 32'(done3));
      last3 = e3;
      $display("convert %0d: latency=%0d busy=%0d", v, k, busy_cnt);
   endtask

   initial begin
      #2;
      chk("reset_busy", 32'(busy3), 32'd0);
      chk("reset_done", 32'(done3), 32'd0);
      chk("reset_bcd", 32'(bcd3), 32'd0);
      chk("reset_ovf", 32'(ovf3), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      convert(8'd0,   12'h000, 1'b0, 8'h00, 1'b0, 0);
      convert(8'd255, 12'h255, 1'b0, 8'h55, 1'b1, 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done3), 32'd0);
      // Back-to-back at minimum spacing.
      convert(8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 0);
      convert(8'd10,  12'h010, 1'b0, 8'h10, 1'b0, 0);
      convert(8'd37,  12'h037, 1'b0, 8'h37, 1'b0, 3);
      repeat (12) @(negedge clk);
      chk("no_extra_done", 32'(q3.size()), 32'd0);

      // Reset four cycles into a conversion of 123.
      @(negedge clk);
      start = 1'b1; bin_in = 8'd123;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy3), 32'd0);
      chk("abort_bcd", 32'(bcd3), 32'd0);
      chk("abort_ovf", 32'(ovf3), 32'd0);
      chk("abort_bcd2", 32'(bcd2), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last3 = 12'h000;
      repeat (12) @(negedge clk);
      chk("abort_no_done", 32'(done3), 32'd0);

      convert(8'd123, 12'h123, 1'b0, 8'h23, 1'b1, 0);
      convert(8'd100, 12'h100, 1'b0, 8'h00, 1'b1, 0);
      convert(8'd99,  12'h099, 1'b0, 8'h99, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("queue3_drained", 32'(q3.size()), 32'd0);
      chk("queue2_drained", 32'(q2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
